mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//   Multi-cycle controller for the MUL instruction (opcode 6'h1c). Sits beside
//   the EX stage. Accepts operands when decode flags a MUL. Runs an iterative
//   shift-add multiply over WIDTH cycles and stalls the pipeline meanwhile.
//   Presents the 2*WIDTH-bit product, with a one-cycle done pulse, for writeback.
// PARAMETERS
//   WIDTH    32   operand width in bits; product is 2*WIDTH bits
//   CNT_W    6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request: decoded MUL present in EX with valid operands
//   signed_op  in   1      1 = two's-complement multiply, 0 = unsigned
//   op_a       in   WIDTH  multiplicand (rs value)
//   op_b       in   WIDTH  multiplier (rt value)
//   flush      in   1      abort in-flight op (branch/exception squash)
//   busy       out  1      high in RUN and FIX states
//   stall      out  1      freeze IF/ID/EX; combinational
//   done       out  1      one-cycle pulse: result_hi/lo valid
//   result_hi  out  WIDTH  upper half of product
//   result_lo  out  WIDTH  lower half of product
// BEHAVIOUR
//   Reset: state=IDLE. busy, done, result_hi and result_lo are 0. Counter is 0.
//     All internal regs are 0. Reset is honoured in any state, mid-op included.
//   FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//   IDLE, start=1, flush=0: latch operand magnitudes.
//     - Unsigned: use operands as-is.
//     - Signed: use |op_a| and |op_b|.
//     - neg_flag = signed_op & (op_a[W-1] ^ op_b[W-1]).
//     - acc(WIDTH+1 bits) = 0, count = WIDTH. Go to RUN.
//   RUN, each cycle:
//     - If mplier[0], acc = acc + mcand.
//     - Then {acc,mplier} shifts right 1 (logical), and count decrements.
//     - When count reaches 1 and that iteration completes, go to FIX.
//   FIX: product P = {acc[W-1:0], mplier}. If neg_flag, P = -P (2*WIDTH-bit
//     two's complement). Register P into result_hi/result_lo. Go to DONE.
//   DONE: done=1 for exactly this cycle. Go to IDLE.
//   Latency: start accepted in cycle 0. RUN occupies cycles 1..WIDTH. FIX is
//     cycle WIDTH+1. done=1 in cycle WIDTH+2, which is 34 for WIDTH=32.
//     Latency is fixed and independent of operand values and signedness.
//   stall = (state==IDLE & start & ~flush) | (state==RUN) | (state==FIX).
//     stall is low in DONE, so the MUL leaves EX in the done cycle.
//   result_hi/lo: hold their value until the next FIX. Unchanged by flush.
//   -|0x80000000| = 0x80000000 as unsigned magnitude; this is correct.
//   start while busy or in DONE: ignored, no effect on the current op.
//   flush in RUN or FIX: next state IDLE. No done pulse. Results not updated.
//     stall falls in the following cycle.
//   flush in DONE: done still pulses (result already committed).
//   flush and start together in IDLE: flush wins, and the op is not accepted.
// TESTING
//   1 unsigned op_a=7, op_b=6 -> done in cycle 34; hi=0x00000000, lo=0x0000002A.
//   2 unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//   3 signed -3*5 (0xFFFFFFFD, 0x00000005) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//     signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
//   4 flush in cycle 10 of test 1 -> stall=0 in cycle 11, done never pulses,
//     result keeps the previous value. start again -> correct product.
//   5 start re-asserted in cycles 1..33 with different operands -> ignored,
//     test-1 result unchanged. stall high in cycles 0..33, low in cycle 34.
//   6 reset asserted in cycle 15 -> busy, stall, done and results are 0
//     immediately (asynchronous). After release, a new op completes normally.

Source files
------------

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL sequencer beside the EX stage.
// Iterative shift-add multiply over WIDTH RUN cycles. A FIX cycle applies the
// sign and commits the product. A DONE cycle pulses done for writeback.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic [WIDTH-1:0]   res_hi_q, res_lo_q;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;

  // Flush beats start, so a squashed MUL is never accepted.
  assign accept    = (state_q == S_IDLE) & start & ~flush;
  assign last_iter = (cnt_q == CNT_W'(1));

  // The multiply works on magnitudes. The most negative value maps onto
  // itself, and that value is also the correct unsigned magnitude.
  assign mag_a    = (signed_op & op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b    = (signed_op & op_b[WIDTH-1]) ? -op_b : op_b;
  assign addend   = mplier_q[0] ? mcand_q : '0;
  assign sum      = acc_q + {1'b0, addend};
  assign prod_mag = {acc_q[WIDTH-1:0], mplier_q};
  assign prod_fix = neg_q ? -prod_mag : prod_mag;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Flush in RUN or FIX abandons the op. DONE always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN:  if (flush) state_d = S_IDLE;
              else if (last_iter) state_d = S_FIX;
      S_FIX:  state_d = flush ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. stall rises in the accept cycle and drops in the DONE cycle.
  always_comb begin
    busy  = (state_q == S_RUN) | (state_q == S_FIX);
    done  = (state_q == S_DONE);
    stall = accept | busy;
  end

  // Datapath: latch operands, run one shift-add step per RUN cycle, commit in FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      if (accept) begin
        mcand_q  <= mag_a;
        mplier_q <= mag_b;
        acc_q    <= '0;
        cnt_q    <= CNT_W'(WIDTH);
        neg_q    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      end
      if (state_q == S_RUN) begin
        acc_q    <= {1'b0, sum[WIDTH:1]};
        mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
        cnt_q    <= cnt_q - CNT_W'(1);
      end
      if (state_q == S_FIX && !flush) begin
        res_hi_q <= prod_fix[2*WIDTH-1:WIDTH];
        res_lo_q <= prod_fix[WIDTH-1:0];
      end
    end
  end

  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer. A cycle-level behavioural model tracks how far an
// accepted op has progressed and which product is committed. Directed ops
// also check hand-computed literal results.
module tb_mul_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, stall, done;
  logic [W-1:0] result_hi, result_lo;

  int nchk = 0;
  int nerr = 0;

  mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy), .stall(stall),
    .done(done), .result_hi(result_hi), .result_lo(result_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Model: phase 0 = idle, 1..W+1 = op in flight, W+2 = done cycle.
  int          phase = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_res = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 0;
      m_res <= '0;
    end else if (phase == 0) begin
      if (start && !flush) begin
        m_pend <= ref_prod(op_a, op_b, signed_op);
        phase  <= 1;
      end
    end else if (phase <= W + 1) begin
      if (flush) phase <= 0;
      else if (phase == W + 1) begin
        m_res <= m_pend;
        phase <= W + 2;
      end else phase <= phase + 1;
    end else begin
      phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", busy, (phase >= 1 && phase <= W + 1));
      chk("done", done, (phase == W + 2));
      chk("stall", stall, (phase >= 1 && phase <= W + 1) || (phase == 0 && start && !flush));
      chk("result_hi", result_hi, m_res[63:32]);
      chk("result_lo", result_lo, m_res[31:0]);
    end
  end

  // Issue one op in cycle 0. Optional flush cycle, flush during DONE,
  // start re-assertion while busy, and reset cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int flush_cyc, input bit fl_done, input bit reassert,
                       input int rst_cyc, output int done_cyc);
    done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b; signed_op = s; flush = 1'b0;
    @(negedge clk);
    chk("stall_cycle0", stall, 1);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      start = reassert && (k <= 33);
      if (reassert) begin
        op_a = $urandom; op_b = $urandom; signed_op = k[0];
      end
      flush = (k == flush_cyc) || (fl_done && k == W + 2);
      if (k == rst_cyc) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_lo", result_lo, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
      @(negedge clk);
      if (reassert) chk("stall_hold", stall, (k <= 33));
      if (flush_cyc > 0 && k == flush_cyc + 1) begin
        chk("stall_after_flush", stall, 0);
        break;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int dc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_stall", stall, 0);
    chk("reset_hi", result_hi, 0);
    chk("reset_lo", result_lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 7*6 unsigned
    do_op(32'd7, 32'd6, 1'b0, 0, 0, 0, 0, dc);
    chk("t1_done_cycle", dc, 34);
    chk("t1_hi", result_hi, 32'h0);
    chk("t1_lo", result_lo, 32'h2A);

    // all-ones squared
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0, 0, 0, dc);
    chk("t2_done_cycle", dc, 34);
    chk("t2_hi", result_hi, 32'hFFFFFFFE);
    chk("t2_lo", result_lo, 32'h00000001);

    // signed -3*5 and most-negative squared
    do_op(32'hFFFFFFFD, 32'h5, 1'b1, 0, 0, 0, 0, dc);
    chk("t3_done_cycle", dc, 34);
    chk("t3_hi", result_hi, 32'hFFFFFFFF);
    chk("t3_lo", result_lo, 32'hFFFFFFF1);
    do_op(32'h80000000, 32'h80000000, 1'b1, 0, 0, 0, 0, dc);
    chk("t3b_hi", result_hi, 32'h40000000);
    chk("t3b_lo", result_lo, 32'h00000000);

    // flush in cycle 10: no done, result keeps previous value
    do_op(32'd7, 32'd6, 1'b0, 10, 0, 0, 0, dc);
    chk("t4_no_done", dc, -1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_hi_kept", result_hi, 32'h40000000);
    chk("t4_lo_kept", result_lo, 32'h0);
    do_op(32'd7, 32'd6, 1'b0, 0, 0, 0, 0, dc);
    chk("t4_redo_cycle", dc, 34);
    chk("t4_redo_lo", result_lo, 32'h2A);

    // start and flush together in IDLE: not accepted
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op_a = 32'd3; op_b = 32'd3; signed_op = 1'b0;
    @(negedge clk);
    chk("sf_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("sf_busy", busy, 0);

    // flush during DONE: done still pulses, result committed
    do_op(32'd9, 32'd9, 1'b0, 0, 1, 0, 0, dc);
    chk("fd_done_cycle", dc, 34);
    chk("fd_lo", result_lo, 32'd81);

    // start re-asserted while busy is ignored
    do_op(32'd7, 32'd6, 1'b0, 0, 0, 1, 0, dc);
    chk("t5_done_cycle", dc, 34);
    chk("t5_hi", result_hi, 32'h0);
    chk("t5_lo", result_lo, 32'h2A);

    // asynchronous reset mid-op, then a fresh op
    do_op(32'd11, 32'd13, 1'b0, 0, 0, 0, 15, dc);
    chk("t6_no_done", dc, -1);
    do_op(32'h12345678, 32'h100, 1'b0, 0, 0, 0, 0, dc);
    chk("t6_done_cycle", dc, 34);
    chk("t6_hi", result_hi, 32'h00000012);
    chk("t6_lo", result_lo, 32'h34567800);
    do_op(32'd7, 32'hFFFFFFFF, 1'b1, 0, 0, 0, 0, dc);
    chk("t6b_hi", result_hi, 32'hFFFFFFFF);
    chk("t6b_lo", result_lo, 32'hFFFFFFF9);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
